// File: rtl/wb_write_queue.sv
// wb_write_queue: write-back queue in front of the register file write port.
// Collects ALU and load results, holds them in an in-order FIFO, drains one
// write per cycle, and forwards still-pending values to the two read ports.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   alu_wb_en/alu_dest/alu_data    ALU result request
//   mem_wb_en/mem_dest/mem_data    load result request (older than ALU)
//   src1, src2                     register file read addresses
//   stall                          fewer than 2 free entries
//   reg_write/reg_dest/data        registered write port to the register file
//   hit1/fwd1, hit2/fwd2           forwarding lookups for src1/src2
//   overflow                       sticky: a request was dropped
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned size  = 4,
  parameter int unsigned len   = 32,
  parameter int unsigned count = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_wb_en,
  input  logic [size-1:0] alu_dest,
  input  logic [len-1:0]  alu_data,
  input  logic            mem_wb_en,
  input  logic [size-1:0] mem_dest,
  input  logic [len-1:0]  mem_data,
  input  logic [size-1:0] src1,
  input  logic [size-1:0] src2,
  output logic            stall,
  output logic            reg_write,
  output logic [size-1:0] reg_dest,
  output logic [len-1:0]  data,
  output logic            hit1,
  output logic [len-1:0]  fwd1,
  output logic            hit2,
  output logic [len-1:0]  fwd2,
  output logic            overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [size:0] CNT = (size+1)'(count);

  logic [size-1:0] dest_q [DEPTH];
  logic [len-1:0]  data_q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [OW-1:0]   occ;

  logic            mem_ok_c;
  logic            alu_ok_c;
  logic            pop_c;
  logic [OW:0]     free_c;
  logic            mem_acc_c;
  logic            alu_acc_c;
  logic            drop_c;
  logic [PW-1:0]   alu_ptr_c;
  logic [OW-1:0]   occ_nxt_c;

  // Request filtering and slot allocation; a same-cycle pop frees a slot.
  always_comb begin
    mem_ok_c  = mem_wb_en && ({1'b0, mem_dest} < CNT);
    alu_ok_c  = alu_wb_en && ({1'b0, alu_dest} < CNT);
    pop_c     = (occ != '0);
    free_c    = (OW+1)'(DEPTH) - {1'b0, occ} + (OW+1)'(pop_c);
    mem_acc_c = mem_ok_c && (free_c != '0);
    alu_acc_c = alu_ok_c && (free_c > (OW+1)'(mem_acc_c));
    drop_c    = (mem_ok_c && !mem_acc_c) || (alu_ok_c && !alu_acc_c);
    alu_ptr_c = wr_ptr + PW'(mem_acc_c);
    occ_nxt_c = occ + OW'(mem_acc_c) + OW'(alu_acc_c) - OW'(pop_c);
  end

  assign stall = (occ > OW'(DEPTH - 2));

  // FIFO storage, pointers, drain register and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      reg_write <= 1'b0;
      reg_dest  <= '0;
      data      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (mem_acc_c) begin
        dest_q[wr_ptr] <= mem_dest;
        data_q[wr_ptr] <= mem_data;
      end
      if (alu_acc_c) begin
        dest_q[alu_ptr_c] <= alu_dest;
        data_q[alu_ptr_c] <= alu_data;
      end
      wr_ptr    <= wr_ptr + PW'(mem_acc_c) + PW'(alu_acc_c);
      occ       <= occ_nxt_c;
      reg_write <= pop_c;
      if (pop_c) begin
        reg_dest <= dest_q[rd_ptr];
        data     <= data_q[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Youngest matching pending write wins: scan output register, then head to tail.
  function automatic logic [len:0] lookup(input logic [size-1:0] src);
    logic [len:0]  res;
    logic [PW-1:0] idx;
    res = '0;
    if (reg_write && (reg_dest == src)) res = {1'b1, data};
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_ptr + PW'(i);
      if ((OW'(i) < occ) && (dest_q[idx] == src)) res = {1'b1, data_q[idx]};
    end
    if ({1'b0, src} >= CNT) res = '0;
    return res;
  endfunction

  assign {hit1, fwd1} = lookup(src1);
  assign {hit2, fwd2} = lookup(src2);

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue (DEPTH=4, size=4, len=32, count=15).
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_en, mem_wb_en;
  logic [3:0]  alu_dest, mem_dest, src1, src2;
  logic [31:0] alu_data, mem_data;
  logic        stall, reg_write, hit1, hit2, overflow;
  logic [3:0]  reg_dest;
  logic [31:0] data, fwd1, fwd2;

  int n_cmp = 0;
  int n_err = 0;

  wb_write_queue #(.DEPTH(4), .size(4), .len(32), .count(15)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_en(alu_wb_en), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_data(mem_data),
    .src1(src1), .src2(src2), .stall(stall),
    .reg_write(reg_write), .reg_dest(reg_dest), .data(data),
    .hit1(hit1), .fwd1(fwd1), .hit2(hit2), .fwd2(fwd2),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_wb_en = 1'b0; alu_dest = '0; alu_data = '0;
    mem_wb_en = 1'b0; mem_dest = '0; mem_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    src1 = 4'd0; src2 = 4'd0;
    rst = 1'b0;
    #12;
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL reset_reg_write got %b exp 0", reg_write); end
    n_cmp++; if (reg_dest !== 4'd0) begin n_err++; $display("FAIL reset_reg_dest got %h exp 0", reg_dest); end
    n_cmp++; if (data !== 32'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", data); end
    n_cmp++; if (stall !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got stall=%b ovf=%b exp 0 0", stall, overflow); end
    n_cmp++; if (hit1 !== 1'b0 || hit2 !== 1'b0 || fwd1 !== 32'd0 || fwd2 !== 32'd0) begin
      n_err++; $display("FAIL reset_fwd got %b %b %h %h exp 0 0 0 0", hit1, hit2, fwd1, fwd2); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    alu_wb_en = 1'b1; alu_dest = 4'd3; alu_data = 32'h11;
    src1 = 4'd3; src2 = 4'd3;
    tick();
    idle();
    #1;
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL single_latency got %b exp 0", reg_write); end
    n_cmp++; if (hit1 !== 1'b1 || fwd1 !== 32'h11) begin n_err++; $display("FAIL single_fwd1_queued got %b/%h exp 1/11", hit1, fwd1); end
    tick();
    n_cmp++; if (reg_write !== 1'b1 || reg_dest !== 4'd3 || data !== 32'h11) begin
      n_err++; $display("FAIL single_write got %b/%h/%h exp 1/3/11", reg_write, reg_dest, data); end
    n_cmp++; if (hit2 !== 1'b1 || fwd2 !== 32'h11) begin n_err++; $display("FAIL single_fwd2_outreg got %b/%h exp 1/11", hit2, fwd2); end
    tick();
    n_cmp++; if (reg_write !== 1'b0 || data !== 32'h11) begin n_err++; $display("FAIL single_done got %b/%h exp 0/11", reg_write, data); end
    n_cmp++; if (hit1 !== 1'b0 || fwd1 !== 32'd0) begin n_err++; $display("FAIL single_nohit got %b/%h exp 0/0", hit1, fwd1); end
  endtask

  task automatic test_same_reg();
    mem_wb_en = 1'b1; mem_dest = 4'd5; mem_data = 32'hAA;
    alu_wb_en = 1'b1; alu_dest = 4'd5; alu_data = 32'hBB;
    src1 = 4'd5; src2 = 4'd6;
    tick();
    idle();
    n_cmp++; if (hit1 !== 1'b1 || fwd1 !== 32'hBB) begin n_err++; $display("FAIL same_youngest got %b/%h exp 1/bb", hit1, fwd1); end
    n_cmp++; if (hit2 !== 1'b0) begin n_err++; $display("FAIL same_src2_miss got %b exp 0", hit2); end
    tick();
    n_cmp++; if (reg_write !== 1'b1 || reg_dest !== 4'd5 || data !== 32'hAA) begin
      n_err++; $display("FAIL same_first got %b/%h/%h exp 1/5/aa", reg_write, reg_dest, data); end
    n_cmp++; if (fwd1 !== 32'hBB) begin n_err++; $display("FAIL same_fifo_over_out got %h exp bb", fwd1); end
    tick();
    n_cmp++; if (reg_write !== 1'b1 || reg_dest !== 4'd5 || data !== 32'hBB) begin
      n_err++; $display("FAIL same_second got %b/%h/%h exp 1/5/bb", reg_write, reg_dest, data); end
    tick();
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL same_idle got %b exp 0", reg_write); end
  endtask

  task automatic test_pc_filter();
    alu_wb_en = 1'b1; alu_dest = 4'd15; alu_data = 32'hDEAD;
    src1 = 4'd15; src2 = 4'd15;
    tick();
    idle();
    n_cmp++; if (hit1 !== 1'b0 || hit2 !== 1'b0) begin n_err++; $display("FAIL pc_hit got %b %b exp 0 0", hit1, hit2); end
    tick();
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL pc_write got %b exp 0", reg_write); end
    n_cmp++; if (overflow !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL pc_flags got ovf=%b stall=%b exp 0 0", overflow, stall); end
  endtask

  task automatic test_overflow();
    logic [3:0]  got_d[$];
    logic [31:0] got_v[$];
    logic [3:0]  exp_d[7];
    logic [31:0] exp_v[7];
    logic        exp_stall[4];
    exp_d = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3};
    exp_v = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1};
    src1 = 4'd10; src2 = 4'd11;
    for (int c = 0; c < 4; c++) begin
      mem_wb_en = 1'b1; mem_dest = 4'(c);     mem_data = 32'h100 + 32'(c);
      alu_wb_en = 1'b1; alu_dest = 4'(8 + c); alu_data = 32'h200 + 32'(c);
      tick();
      n_cmp++; if (stall !== exp_stall[c]) begin n_err++; $display("FAIL ovf_stall_c%0d got %b exp %b", c, stall, exp_stall[c]); end
      n_cmp++; if (overflow !== (c == 3)) begin n_err++; $display("FAIL ovf_flag_c%0d got %b exp %b", c, overflow, (c == 3)); end
      if (reg_write) begin got_d.push_back(reg_dest); got_v.push_back(data); end
    end
    idle();
    n_cmp++; if (hit1 !== 1'b1 || fwd1 !== 32'h202 || hit2 !== 1'b0) begin
      n_err++; $display("FAIL ovf_fwd got %b/%h %b exp 1/202 0", hit1, fwd1, hit2); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (reg_write) begin got_d.push_back(reg_dest); got_v.push_back(data); end
    end
    n_cmp++; if (got_d.size() != 7) begin n_err++; $display("FAIL ovf_drain_count got %0d exp 7", got_d.size()); end
    for (int k = 0; k < 7; k++) begin
      if (k < got_d.size()) begin
        n_cmp++; if (got_d[k] !== exp_d[k] || got_v[k] !== exp_v[k]) begin
          n_err++; $display("FAIL ovf_order_%0d got %h/%h exp %h/%h", k, got_d[k], got_v[k], exp_d[k], exp_v[k]); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_ovf_cleared got %b exp 0", overflow); end
    @(posedge clk); #1;
    mem_wb_en = 1'b1; mem_dest = 4'd1; mem_data = 32'h1;
    alu_wb_en = 1'b1; alu_dest = 4'd2; alu_data = 32'h2;
    tick();
    mem_dest = 4'd3; mem_data = 32'h3; alu_dest = 4'd4; alu_data = 32'h4;
    tick();
    idle();
    src1 = 4'd4; src2 = 4'd1;
    #1;
    n_cmp++; if (stall !== 1'b1 || reg_write !== 1'b1 || hit1 !== 1'b1 || hit2 !== 1'b1) begin
      n_err++; $display("FAIL mid_prefill got stall=%b wr=%b h1=%b h2=%b exp 1 1 1 1", stall, reg_write, hit1, hit2); end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (reg_write !== 1'b0 || stall !== 1'b0 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
      n_err++; $display("FAIL mid_async got wr=%b stall=%b h1=%b h2=%b exp 0 0 0 0", reg_write, stall, hit1, hit2); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    alu_wb_en = 1'b1; alu_dest = 4'd7; alu_data = 32'h77;
    tick();
    idle();
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL mid_after_latency got %b exp 0", reg_write); end
    tick();
    n_cmp++; if (reg_write !== 1'b1 || reg_dest !== 4'd7 || data !== 32'h77) begin
      n_err++; $display("FAIL mid_after_write got %b/%h/%h exp 1/7/77", reg_write, reg_dest, data); end
    tick();
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL mid_after_empty got %b exp 0", reg_write); end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    src1 = 4'd0; src2 = 4'd0;
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        alu_wb_en = 1'b1; alu_dest = 4'(c); alu_data = 32'h300 + 32'(c);
      end else begin
        idle();
      end
      tick();
      if (stall) stalls++;
      if (c >= 1 && c <= 10) begin
        n_cmp++; if (reg_write !== 1'b1 || reg_dest !== 4'(c - 1) || data !== 32'h300 + 32'(c - 1)) begin
          n_err++; $display("FAIL b2b_write_%0d got %b/%h/%h exp 1/%h/%h", c - 1, reg_write, reg_dest, data, 4'(c - 1), 32'h300 + 32'(c - 1)); end
      end
    end
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", reg_write); end
    n_cmp++; if (stalls != 0) begin n_err++; $display("FAIL b2b_stall got %0d cycles exp 0", stalls); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    src1 = '0; src2 = '0;
    test_reset();
    test_single();
    test_same_reg();
    test_pc_filter();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back side of the CPU register file. Collects completed results from the ALU path and the memory-load path, buffers them in a small in-order FIFO, and drains one write per cycle onto the register file's write port (reg_write / reg_dest / data).
- Also provides forwarding lookups on the register file's two read addresses, so ID reads see results that are still queued.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2)
- size, 4, register address width
- len, 32, data width
- count, 15, number of architectural registers; addresses at or above count are not writable

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- alu_wb_en  in  1  ALU result valid this cycle
- alu_dest  in  size  ALU destination register
- alu_data  in  len  ALU result
- mem_wb_en  in  1  load result valid this cycle
- mem_dest  in  size  load destination register
- mem_data  in  len  load data
- src1  in  size  read address 1 (same as register file src1)
- src2  in  size  read address 2
- stall  out  1  fewer than 2 free entries; producers must hold off
- reg_write  out  1  write strobe to register file
- reg_dest  out  size  write address to register file
- data  out  len  write data to register file
- hit1  out  1  src1 matches a pending write
- fwd1  out  len  forwarded value for src1
- hit2  out  1  src2 matches a pending write
- fwd2  out  len  forwarded value for src2
- overflow  out  1  sticky error flag: a write was dropped

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty, pointers and occupancy 0.
  - reg_write=0, reg_dest=0, data=0, overflow=0.
  - stall=0, hit1=hit2=0, fwd1=fwd2=0.
- Filtering: a request with dest >= count (address 15 = PC) is discarded silently. It is not enqueued, does not set overflow and is not counted.
- Enqueue order when both sources are valid in one cycle:
  - mem entry is written first (older), then alu entry.
  - Both land in the same cycle.
- Drain:
  - On each posedge, if the FIFO is non-empty, the head is popped into the output register: reg_write=1, reg_dest/data = head.
  - Otherwise reg_write=0; reg_dest/data hold their last value.
- Latency: an entry enqueued at edge N into an empty FIFO appears on reg_write at edge N+1. Throughput is 1 write per cycle.
- Simultaneous push and pop: occupancy is computed as occ + pushes − pop. A pop frees a slot in the same cycle, available to pushes.
- stall = (DEPTH − occ) < 2. It is combinational from registered occupancy and does not depend on the current inputs.
- Overflow handling:
  - If pushes exceed free slots after the pop, the excess is dropped, younger request first (the alu entry when both are valid).
  - overflow sets and stays set until reset.
- Forwarding (combinational):
  - hit1/fwd1 search the FIFO entries and the output register (when reg_write=1) for dest == src1.
  - If several match, the youngest wins. Priority order, youngest to oldest: FIFO tail ... FIFO head, then output register.
  - No match gives hit1=0, fwd1=0. src1 >= count always gives hit1=0. Same rules for src2.
  - Current-cycle inputs (alu_*/mem_*) are not forwarded.
- Wrap-around: pointers are modulo DEPTH; occupancy is tracked explicitly (0..DEPTH), so full and empty are distinguishable.
- Reset mid-operation: all queued writes are lost and reg_write deasserts immediately (asynchronously).
- Ordering: writes reach the register file in exact enqueue order. Two writes to the same register are never merged.

Test Plan:
- Reset, then alu_wb_en=1, alu_dest=3, alu_data=0x11 for one cycle -> the next cycle shows reg_write=1, reg_dest=3, data=0x11; the cycle after shows reg_write=0.
- Same cycle: mem (dest 5, 0xAA) and alu (dest 5, 0xBB); src1=5 -> after the enqueue edge, hit1=1, fwd1=0xBB. The register file sees 5←0xAA, then 5←0xBB on consecutive cycles.
- alu_dest=15 with alu_wb_en=1 -> no reg_write, occupancy unchanged, overflow=0, hit on src1=15 is 0.
- Both sources valid for 4 consecutive cycles with DEPTH=4:
  - stall asserts when occupancy reaches 3.
  - Driving on regardless makes overflow=1 with the alu entries dropped.
  - Drained writes match the accepted order exactly.
- Fill to 3 entries, assert rst low mid-cycle -> reg_write, stall, hit1/hit2 are 0 immediately. After rst high, new writes drain normally from an empty FIFO.
- Continuous single-source stream of 10 writes (dest 0..9) -> reg_write held high for 10 consecutive cycles, pointers wrap, stall never asserts.
